// File: rtl/miner_work_loader.sv
// Work-block loader: gathers host word writes into a shadow buffer and commits the full
// block atomically to the miner cores, holding them in reset while they restart.
module miner_work_loader #(
  parameter int WORD_W         = 32,
  parameter int WORDS          = 36,
  parameter int ADDR_W         = 6,
  parameter int RESTART_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     wr_last,
  input  logic                     err_clear,
  output logic [WORDS*WORD_W-1:0]  block,
  output logic                     work_valid,
  output logic                     miner_reset,
  output logic [7:0]               work_gen,
  output logic                     err_addr,
  output logic                     err_incomplete
);

  localparam int BLK_W = WORDS * WORD_W;
  localparam int CNT_W = $clog2(RESTART_CYCLES + 1);
  localparam logic [ADDR_W:0] WORDS_L  = (ADDR_W+1)'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(RESTART_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESTART = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   shadow_q, shadow_d;
  logic [WORDS-1:0]   mask_q, mask_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic [7:0]         gen_q, gen_d;
  logic               wv_q, wv_d;
  logic               mrst_q, mrst_d;
  logic               ea_q, ea_d;
  logic               ei_q, ei_d;

  logic               wr_fire;
  logic               in_range;

  // Writes are refused while the cores restart and while reset is held.
  assign wr_ready = !reset && (state_q != RESTART);
  assign wr_fire  = wr_valid && wr_ready;
  assign in_range = ({1'b0, wr_addr} < WORDS_L);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    block_d  = block_q;
    gen_d    = gen_q;
    wv_d     = wv_q;
    // A new error event in the same cycle as err_clear keeps the flag set.
    ea_d     = ea_q & ~err_clear;
    ei_d     = ei_q & ~err_clear;

    case (state_q)
      IDLE, FILL: begin
        if (wr_fire) begin
          if (!in_range) begin
            ea_d = 1'b1;
          end else begin
            shadow_d[wr_addr*WORD_W +: WORD_W] = wr_data;
            mask_d[wr_addr]                    = 1'b1;
            state_d                            = FILL;
            if (wr_last) begin
              if (&mask_d) begin
                block_d = shadow_d;
                gen_d   = gen_q + 8'd1;
                wv_d    = 1'b1;
                cnt_d   = CNT_LD;
                state_d = RESTART;
              end else begin
                ei_d    = 1'b1;
              end
            end
          end
        end
      end
      RESTART: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mrst_d = (state_d == RESTART) || !wv_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      block_q  <= '0;
      gen_q    <= '0;
      wv_q     <= 1'b0;
      mrst_q   <= 1'b1;
      ea_q     <= 1'b0;
      ei_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      block_q  <= block_d;
      gen_q    <= gen_d;
      wv_q     <= wv_d;
      mrst_q   <= mrst_d;
      ea_q     <= ea_d;
      ei_q     <= ei_d;
    end
  end

  assign block          = block_q;
  assign work_valid     = wv_q;
  assign miner_reset    = mrst_q;
  assign work_gen       = gen_q;
  assign err_addr       = ea_q;
  assign err_incomplete = ei_q;

endmodule
